song_reader: RTL and testbench
==============================

# song_reader

Sequencer that drives the note player: walks a song ROM note by note, presents each note/duration pair with a one-cycle load strobe, waits for the player's completion pulse, then fetches the next entry. Sits between the top-level music controller (play, next-song buttons) and the note player's load/done handshake. It owns the song ROM and the current song number.

## Interface
Parameters:
- SONG_W, 2: song-select width; 4 songs.
- IDX_W, 5: note-index width; 32 entries per song.
- NOTE_W, 6: note and duration field width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- play  in  1  level; 1 = sequencing allowed, 0 = paused
- next_song  in  1  one-cycle pulse; advance to the next song
- note_done  in  1  one-cycle pulse from the note player; current note finished
- song  out  SONG_W  current song number
- song_done  out  1  one-cycle pulse; current song reached its end
- note_to_load  out  NOTE_W  registered note for the player
- duration_to_load  out  NOTE_W  registered duration in beats
- load_new_note  out  1  one-cycle strobe; note/duration valid this cycle

## Operation
- ROM address = {song, idx}, 128 entries × 12 bits, data = {note[11:6], duration[5:0]}.
  - Synchronous read: data is valid one cycle after the address is presented.
- FSM states and transitions:
  - FETCH: present address. If play=1, go to LOAD; otherwise hold.
  - LOAD: ROM data is valid. If duration==0 (end marker), go to DONE. Otherwise, on the clock edge:
    - capture note/duration into the output registers,
    - set load_new_note=1 for exactly one cycle,
    - go to WAIT.
  - WAIT: on note_done, if idx==31 go to DONE, else idx←idx+1 and go to FETCH. note_done is accepted regardless of play.
  - DONE: song_done=1 on the entry cycle only; idx←0. Hold until next_song.
- next_song: in any state, song←song+1 (wraps 3→0), idx←0, state←FETCH. Any note in progress is abandoned and load_new_note is not asserted that cycle.
- Priority: reset > next_song > note_done.
- note_done outside WAIT is ignored. next_song is accepted while play=0.
- play=0 in LOAD: hold in LOAD with no capture. Capture proceeds when play returns to 1.
- note_to_load and duration_to_load hold their last values until the next capture.

## Timing
- Reset values:
  - state=FETCH, song=0, idx=0
  - note_to_load=0, duration_to_load=0
  - load_new_note=0, song_done=0
- Reset in the middle of a note abandons it immediately.
- Latency, with play=1:
  - FETCH entry → load_new_note high: 2 cycles.
  - note_done → next load_new_note: 3 cycles (WAIT→FETCH→LOAD→strobe).
- load_new_note and the new note/duration values become visible in the same cycle.
- The end marker is detected in LOAD, so song_done is high 2 cycles after FETCH entry.
- song_done (idx==31 path) is high the cycle after note_done.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package song_pkg:
  - state encoding (FETCH, LOAD, WAIT, DONE),
  - SONG_W, IDX_W, NOTE_W,
  - END_DURATION=0,
  - ROM field positions.
- One sub-module, song_rom (clk, addr[6:0], dout[11:0]), with a synchronous read, matching frequency_rom's interface style.
- Top level contains the FSM, the idx/song counters and the output registers.

## Test plan
- Reset then play=1; ROM song 0 entry 0 = {note 6'd20, dur 6'd4} → load_new_note high at cycle 2, note_to_load=20, duration_to_load=4; no further strobe until note_done.
- note_done pulse in WAIT with song 0 entries 0–2 valid and entry 3 duration=0 → strobes for entries 1 and 2 each 3 cycles after note_done; after the third note_done, song_done pulses once and no strobe follows.
- Full 32-note song 1 (no end marker) → 32 strobes; song_done on the cycle after the 32nd note_done; idx=0.
- next_song asserted in WAIT with note_done in the same cycle → song increments, note_done ignored, strobe for entry 0 of the new song 2 cycles later; song=3 + next_song → song=0.
- play dropped in FETCH for 5 cycles → no strobe; resume → strobe 2 cycles after play rises; note_done while play=0 in WAIT is still accepted.
- reset asserted in WAIT on song 2, idx 7 → next cycle song=0, all outputs zero, sequencing restarts at entry 0.

Source files
------------

// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: widths, ROM word layout, FSM encoding.
package song_pkg;

    localparam int SONG_W = 2;
    localparam int IDX_W  = 5;
    localparam int NOTE_W = 6;
    localparam int ADDR_W = SONG_W + IDX_W;
    localparam int ROM_W  = 2 * NOTE_W;

    // ROM word = {note, duration}
    localparam int NOTE_MSB = 11;
    localparam int NOTE_LSB = 6;
    localparam int DUR_MSB  = 5;
    localparam int DUR_LSB  = 0;

    localparam logic [NOTE_W-1:0] END_DURATION = '0;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_LOAD,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic logic [NOTE_W-1:0] rom_note(input logic [ROM_W-1:0] w);
        return w[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic [NOTE_W-1:0] rom_dur(input logic [ROM_W-1:0] w);
        return w[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/song_rom.sv
// Song ROM, 4 songs x 32 entries of {note, duration}; one-cycle synchronous read.
// Duration 0 marks the end of a song; song 1 fills all 32 slots and has no marker.
module song_rom
    import song_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [ROM_W-1:0]  dout
);

    logic [SONG_W-1:0] sel;
    logic [IDX_W-1:0]  idx;
    logic [NOTE_W-1:0] idx_ext;
    logic [ROM_W-1:0]  rom_word;

    assign sel     = addr[ADDR_W-1:IDX_W];
    assign idx     = addr[IDX_W-1:0];
    assign idx_ext = {1'b0, idx};

    always_comb begin
        rom_word = '0;
        unique case (sel)
            2'd0: begin
                unique case (idx)
                    5'd0:    rom_word = {6'd20, 6'd4};
                    5'd1:    rom_word = {6'd21, 6'd5};
                    5'd2:    rom_word = {6'd22, 6'd6};
                    default: rom_word = '0;
                endcase
            end
            2'd1: rom_word = {idx_ext + 6'd10, {3'b000, idx[2:0]} + 6'd1};
            2'd2: rom_word = idx[4] ? '0 : {idx_ext + 6'd30, 6'd2};
            2'd3: begin
                unique case (idx)
                    5'd0:    rom_word = {6'd40, 6'd8};
                    5'd1:    rom_word = {6'd41, 6'd1};
                    default: rom_word = '0;
                endcase
            end
            default: rom_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        dout <= rom_word;
    end

endmodule

// File: rtl/song_reader.sv
// Walks the song ROM and hands each note to the player with a one-cycle load strobe.
// Strobe 2 cycles after FETCH entry; waits indefinitely for note_done; play=0 stalls FETCH/LOAD.
module song_reader
    import song_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              next_song,
    input  logic              note_done,
    output logic [SONG_W-1:0] song,
    output logic              song_done,
    output logic [NOTE_W-1:0] note_to_load,
    output logic [NOTE_W-1:0] duration_to_load,
    output logic              load_new_note
);

    state_t            state_q, state_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [NOTE_W-1:0] dur_q, dur_d;
    logic              load_q, load_d;
    logic              done_q, done_d;
    logic [ROM_W-1:0]  rom_dout;

    song_rom u_rom (
        .clk  (clk),
        .addr ({song_q, idx_q}),
        .dout (rom_dout)
    );

    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        idx_d   = idx_q;
        note_d  = note_q;
        dur_d   = dur_q;
        load_d  = 1'b0;
        done_d  = 1'b0;

        // next_song preempts whatever the FSM was doing, including a pending note_done
        if (next_song) begin
            song_d  = song_q + SONG_W'(1);
            idx_d   = '0;
            state_d = ST_FETCH;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (play) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    if (play) begin
                        if (rom_dur(rom_dout) == END_DURATION) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            idx_d   = '0;
                        end else begin
                            note_d  = rom_note(rom_dout);
                            dur_d   = rom_dur(rom_dout);
                            load_d  = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (note_done) begin
                        if (idx_q == {IDX_W{1'b1}}) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            idx_d   = '0;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            song_q  <= '0;
            idx_q   <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            load_q  <= load_d;
            done_q  <= done_d;
        end
    end

    assign song             = song_q;
    assign song_done        = done_q;
    assign note_to_load     = note_q;
    assign duration_to_load = dur_q;
    assign load_new_note    = load_q;

endmodule

// File: tb/tb_song_reader.sv
// Directed stimulus with a cycle-stamped expectation queue checked by an independent monitor.
module tb_song_reader;

    logic       clk = 1'b0;
    logic       reset, play, next_song, note_done;
    logic [1:0] song;
    logic       song_done;
    logic [5:0] note_to_load, duration_to_load;
    logic       load_new_note;

    song_reader dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .next_song        (next_song),
        .note_done        (note_done),
        .song             (song),
        .song_done        (song_done),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_done;
        int         at;
        logic [5:0] note;
        logic [5:0] dur;
        logic [1:0] sng;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   bad;

    task automatic push_load(input int at, input int note, input int dur, input int sng);
        exp_t x;
        x.is_done = 1'b0;
        x.at      = at;
        x.note    = 6'(note);
        x.dur     = 6'(dur);
        x.sng     = 2'(sng);
        exp_q.push_back(x);
    endtask

    task automatic push_done(input int at, input int sng);
        exp_t x;
        x.is_done = 1'b1;
        x.at      = at;
        x.note    = '0;
        x.dur     = '0;
        x.sng     = 2'(sng);
        exp_q.push_back(x);
    endtask

    // Monitor: every strobe or song_done must match the oldest expectation exactly.
    always @(negedge clk) begin
        if (load_new_note || song_done) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event cyc=%0d: got load=%0b done=%0b note=%0d dur=%0d song=%0d, required no event",
                         cyc, load_new_note, song_done, note_to_load, duration_to_load, song);
            end else begin
                e   = exp_q.pop_front();
                bad = (cyc != e.at) || (song_done != e.is_done) || (load_new_note == e.is_done) ||
                      (song !== e.sng) ||
                      (!e.is_done && ((note_to_load !== e.note) || (duration_to_load !== e.dur)));
                if (bad) begin
                    n_bad++;
                    $display("FAIL %s_event: got cyc=%0d load=%0b done=%0b note=%0d dur=%0d song=%0d, required cyc=%0d done=%0b note=%0d dur=%0d song=%0d",
                             e.is_done ? "song_done" : "load", cyc, load_new_note, song_done,
                             note_to_load, duration_to_load, song, e.at, e.is_done, e.note, e.dur, e.sng);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse_done();
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_song"}, song, 0);
        check({tag, "_note"}, note_to_load, 0);
        check({tag, "_dur"}, duration_to_load, 0);
        check({tag, "_load"}, load_new_note, 0);
        check({tag, "_song_done"}, song_done, 0);
    endtask

    int k, c, r;

    initial begin
        reset = 1'b1; play = 1'b0; next_song = 1'b0; note_done = 1'b0;
        repeat (3) tick();
        check_zero("reset");

        // Song 0: three notes then end marker
        k = cyc; reset = 1'b0; play = 1'b1;
        push_load(k + 2, 20, 4, 0);
        tick_to(k + 8);
        k = cyc; push_load(k + 3, 21, 5, 0); pulse_done(); tick_to(k + 6);
        k = cyc; push_load(k + 3, 22, 6, 0); pulse_done(); tick_to(k + 6);
        k = cyc; push_done(k + 3, 0);        pulse_done(); tick_to(k + 6);
        pulse_done();                        // ignored in DONE
        tick_to(cyc + 6);

        // Song 1: full 32 notes, no end marker
        k = cyc; next_song = 1'b1; push_load(k + 3, 10, 1, 1);
        tick(); next_song = 1'b0;
        check("song_after_next_1", song, 1);
        c = k + 3;
        for (int i = 0; i < 32; i++) begin
            tick_to(c + 1);
            k = cyc;
            if (i < 31) begin
                push_load(k + 3, i + 11, ((i + 1) % 8) + 1, 1);
                c = k + 3;
            end else begin
                push_done(k + 1, 1);
            end
            pulse_done();
        end
        tick_to(cyc + 4);

        // Song 2 from DONE starts at entry 0
        k = cyc; next_song = 1'b1; push_load(k + 3, 30, 2, 2);
        tick(); next_song = 1'b0;
        check("song_after_next_2", song, 2);
        tick_to(k + 4);

        // next_song and note_done together: note_done must be dropped
        k = cyc; next_song = 1'b1; note_done = 1'b1; push_load(k + 3, 40, 8, 3);
        tick(); next_song = 1'b0; note_done = 1'b0;
        check("song_after_next_3", song, 3);
        tick_to(k + 4);

        // Wrap 3 -> 0
        k = cyc; next_song = 1'b1; push_load(k + 3, 20, 4, 0);
        tick(); next_song = 1'b0;
        check("song_wrap", song, 0);
        tick_to(k + 4);

        // note_done accepted with play=0, then stall in FETCH
        k = cyc; play = 1'b0; pulse_done();
        tick_to(k + 6);
        k = cyc; play = 1'b1; push_load(k + 2, 21, 5, 0);
        tick_to(k + 4);

        // play dropped while in LOAD
        k = cyc; pulse_done();
        tick(); play = 1'b0;
        tick_to(k + 6);
        r = cyc; play = 1'b1; push_load(r + 1, 22, 6, 0);
        tick_to(r + 3);

        // Two back-to-back next_song: song 1 is abandoned before any strobe
        k = cyc; next_song = 1'b1; push_load(k + 4, 30, 2, 2);
        tick(); tick(); next_song = 1'b0;
        check("song_double_next", song, 2);
        c = k + 4;
        for (int i = 1; i <= 7; i++) begin
            tick_to(c + 1);
            k = cyc;
            push_load(k + 3, 30 + i, 2, 2);
            c = k + 3;
            pulse_done();
        end

        // Reset in WAIT on song 2, idx 7
        tick_to(c + 1);
        k = cyc; reset = 1'b1;
        tick(); reset = 1'b0;
        check_zero("mid_reset");
        push_load(k + 3, 20, 4, 0);
        tick_to(k + 8);

        check("pending_expectations", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
